// File: rtl/bw_io_impctl_pkg.sv
// Shared FSM type, code defaults and the saturating code-step helper
// used by the impedance-code averaging stage.
package bw_io_impctl_pkg;

    typedef enum logic {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } state_e;

    localparam int                    CODE_W_DEF    = 8;
    localparam logic [CODE_W_DEF-1:0] CODE_INIT_DEF = 8'h80;

    typedef struct packed {
        logic [31:0] code;
        logic        sat;
    } step_res_t;

    // Moves code by step in the requested direction, pinning at 0 or max_code;
    // sat flags that the request had to be clipped.
    function automatic step_res_t sat_step(
        input logic [31:0] code,
        input logic        dir,
        input logic [31:0] step,
        input logic [31:0] max_code
    );
        step_res_t res;
        res.sat  = 1'b0;
        res.code = code;
        if (dir) begin
            if (code > max_code - step) begin
                res.code = max_code;
                res.sat  = 1'b1;
            end else begin
                res.code = code + step;
            end
        end else begin
            if (code < step) begin
                res.code = '0;
                res.sat  = 1'b1;
            end else begin
                res.code = code - step;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bw_io_impctl_avgwin.sv
// TRACK-mode averaging window: counts comparator votes over WIN update
// events and emits a one-cycle up/down decision when the net vote is strong.
module bw_io_impctl_avgwin #(
    parameter int WIN    = 16,
    parameter int THRESH = 4
) (
    input  logic l2clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_sample,
    input  logic i_comp_up,
    output logic dec_up,
    output logic dec_dn
);

    localparam int                     CNT_W    = $clog2(WIN);
    localparam int                     SUM_W    = $clog2(WIN) + 2;
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(WIN - 1);
    localparam logic signed [SUM_W-1:0] THR_POS = SUM_W'(THRESH);
    localparam logic signed [SUM_W-1:0] THR_NEG = SUM_W'(-THRESH);

    logic [CNT_W-1:0]        r_cnt;
    logic signed [SUM_W-1:0] r_sum;
    logic signed [SUM_W-1:0] w_sum_nxt;
    logic                    w_last;
    logic                    w_decide;

    assign w_sum_nxt = i_comp_up ? (r_sum + SUM_W'(1)) : (r_sum - SUM_W'(1));
    assign w_last    = (r_cnt == CNT_LAST);

    // The closing sample is included in the vote it closes.
    assign w_decide = i_sample & ~i_clr & w_last;
    assign dec_up   = w_decide & (w_sum_nxt >= THR_POS);
    assign dec_dn   = w_decide & (w_sum_nxt <= THR_NEG);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge l2clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_sum <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_sum <= '0;
        end else if (i_sample) begin
            if (w_last) begin
                r_cnt <= '0;
                r_sum <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_sum <= w_sum_nxt;
            end
        end
    end

endmodule

// File: rtl/bw_io_impctl_avgcode.sv
// Impedance-code register with fast stepped acquisition and windowed
// majority tracking, driven by update events from the update-clock generator.
module bw_io_impctl_avgcode
    import bw_io_impctl_pkg::*;
#(
    parameter int              CODE_W    = CODE_W_DEF,
    parameter logic [CODE_W-1:0] CODE_INIT = CODE_INIT_DEF,
    parameter int              ACQ_STEP  = 4,
    parameter int              WIN       = 16,
    parameter int              THRESH    = 4
) (
    input  logic              l2clk,
    input  logic              reset,
    input  logic              updclk,
    input  logic              bypass,
    input  logic              avgcntr_rst,
    input  logic              comp_up,
    output logic [CODE_W-1:0] imp_code,
    output logic              code_upd,
    output logic              locked,
    output logic              sat_hi,
    output logic              sat_lo
);

    localparam logic [31:0] MAX_CODE = 32'((64'd1 << CODE_W) - 64'd1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_updclk_s;
    logic              r_updclk_q;
    logic              w_upd_ev;
    logic [1:0]        r_rev;
    logic [1:0]        w_rev_nxt;
    logic              r_have_dir;
    logic              w_have_dir_nxt;
    logic              r_last_dir;
    logic              w_last_dir_nxt;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_nxt;
    logic              r_code_upd;
    logic              r_sat_hi;
    logic              r_sat_lo;
    logic              w_dec_up;
    logic              w_dec_dn;
    logic              w_win_clr;
    logic              w_win_sample;
    logic              w_step_dir;
    logic [31:0]       w_step_amt;
    step_res_t         w_step_res;
    logic              w_unused_step;

    // updclk is a level from another block: sample it, then detect its rise.
    assign w_upd_ev = r_updclk_s & ~r_updclk_q;

    assign w_win_clr    = (r_state != TRACK) | bypass | avgcntr_rst;
    assign w_win_sample = (r_state == TRACK) & w_upd_ev;

    bw_io_impctl_avgwin #(
        .WIN    (WIN),
        .THRESH (THRESH)
    ) u_avgwin (
        .l2clk     (l2clk),
        .reset     (reset),
        .i_clr     (w_win_clr),
        .i_sample  (w_win_sample),
        .i_comp_up (comp_up),
        .dec_up    (w_dec_up),
        .dec_dn    (w_dec_dn)
    );

    assign w_step_dir    = (r_state == ACQ) ? comp_up : w_dec_up;
    assign w_step_amt    = (r_state == ACQ) ? 32'(ACQ_STEP) : 32'd1;
    assign w_step_res    = sat_step(32'(r_code), w_step_dir, w_step_amt, MAX_CODE);
    assign w_unused_step = ^{w_step_res.code[31:CODE_W], w_step_res.sat};

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_code_nxt     = r_code;
        w_rev_nxt      = r_rev;
        w_have_dir_nxt = r_have_dir;
        w_last_dir_nxt = r_last_dir;
        case (r_state)
            ACQ: begin
                if (w_upd_ev) begin
                    w_code_nxt     = CODE_W'(w_step_res.code);
                    w_have_dir_nxt = 1'b1;
                    w_last_dir_nxt = comp_up;
                    if (r_have_dir && (comp_up != r_last_dir) && (r_rev != 2'd3)) begin
                        w_rev_nxt = r_rev + 2'd1;
                    end
                end
                if (r_rev[1] && !bypass) begin
                    w_state_nxt = TRACK;
                end
            end
            TRACK: begin
                // A bypass request outranks any decision in the same cycle.
                if (bypass) begin
                    w_state_nxt    = ACQ;
                    w_rev_nxt      = 2'd0;
                    w_have_dir_nxt = 1'b0;
                    w_last_dir_nxt = 1'b0;
                end else if (w_dec_up || w_dec_dn) begin
                    w_code_nxt = CODE_W'(w_step_res.code);
                end
            end
            default: w_state_nxt = ACQ;
        endcase
    end

    always_ff @(posedge l2clk or posedge reset) begin
        if (reset) begin
            r_state    <= ACQ;
            r_updclk_s <= 1'b0;
            r_updclk_q <= 1'b0;
            r_rev      <= 2'd0;
            r_have_dir <= 1'b0;
            r_last_dir <= 1'b0;
            r_code     <= CODE_INIT;
            r_code_upd <= 1'b0;
            r_sat_hi   <= 1'b0;
            r_sat_lo   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_updclk_s <= updclk;
            r_updclk_q <= r_updclk_s;
            r_rev      <= w_rev_nxt;
            r_have_dir <= w_have_dir_nxt;
            r_last_dir <= w_last_dir_nxt;
            r_code     <= w_code_nxt;
            r_code_upd <= (w_code_nxt != r_code);
            r_sat_hi   <= &w_code_nxt;
            r_sat_lo   <= ~|w_code_nxt;
        end
    end

    assign imp_code = r_code;
    assign code_upd = r_code_upd;
    assign locked   = (r_state == TRACK);
    assign sat_hi   = r_sat_hi;
    assign sat_lo   = r_sat_lo;

endmodule

// File: doc/bw_io_impctl_avgcode.md
# bw_io_impctl_avgcode

Impedance-code averaging and update stage sitting directly downstream of the impedance-control update-clock generator. It consumes that block's `updclk`, `bypass` and `avgcntr_rst` outputs together with the synchronized pad comparator result. It produces the 8-bit drive-impedance code that feeds the pad driver legs. It does fast stepped acquisition while bypass is active, then switches to windowed majority averaging for noise-immune tracking.

## Interface
- `CODE_W`, 8: impedance code width.
- `CODE_INIT`, 8'h80: code value at reset.
- `ACQ_STEP`, 4: code step per update during acquisition.
- `WIN`, 16: samples per averaging window (power of two, 4..64).
- `THRESH`, 4: minimum net vote magnitude to move the code in tracking.
- `l2clk`  in  1  block clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `updclk`  in  1  update clock level from the upstream generator; sampled on `l2clk`, never used as a clock.
- `bypass`  in  1  acquisition request; high forces fast stepping.
- `avgcntr_rst`  in  1  synchronous clear of the averaging window.
- `comp_up`  in  1  synchronized comparator: 1 = increase code, 0 = decrease.
- `imp_code`  out  CODE_W  current impedance code.
- `code_upd`  out  1  one-cycle pulse, coincident with a changed `imp_code`.
- `locked`  out  1  high in TRACK state.
- `sat_hi` / `sat_lo`  out  1  code held at all-ones / zero.

## Operation
- Reset values: `imp_code`=CODE_INIT, `code_upd`=0, `locked`=0, `sat_hi`=0, `sat_lo`=0. FSM=ACQ. Window count, vote sum, reversal count and `updclk_q` all 0.
- Update event: `upd_ev = updclk & ~updclk_q`. `updclk_q` is `updclk` registered. `comp_up` is sampled in the same cycle as `upd_ev`.
- FSM states: ACQ, TRACK.
- ACQ:
  - On each `upd_ev`, the code moves ±ACQ_STEP, saturating at 0 or 2^CODE_W-1.
  - A direction differing from the previous ACQ direction increments a 2-bit reversal count. The first event after entering ACQ counts no reversal.
  - ACQ → TRACK when the reversal count reaches 2 and `bypass`=0. At that point the window and sum clear.
  - While `bypass`=1, the FSM stays in ACQ regardless of reversals.
- TRACK:
  - Each `upd_ev` adds +1 (`comp_up`=1) or −1 to a signed sum of width clog2(WIN)+2.
  - On the WIN-th event of a window, including that sample: sum ≥ THRESH → code+1; sum ≤ −THRESH → code−1; otherwise hold.
  - Sum and window count then clear.
  - `bypass`=1 in TRACK → ACQ next cycle. This clears reversals, window and sum, and drops `locked`.
- `avgcntr_rst`=1: clears window count and sum. Any `upd_ev` in the same cycle is discarded in TRACK. `avgcntr_rst` has no effect in ACQ.
- Saturation:
  - A step request beyond a limit leaves the code at the limit and does not pulse `code_upd`.
  - `sat_hi` = (`imp_code` == all-ones); `sat_lo` = (`imp_code` == 0). Both are registered alongside the code.
- `code_upd` pulses only when `imp_code` actually changes.

## Timing
- `updclk` rises before `l2clk` edge k. Then `upd_ev` is high in cycle k.
- The new `imp_code` and `code_upd` appear after edge k+1 (one-cycle latency from event detection).
- Back-to-back events are not possible, since `upd_ev` needs a low `updclk_q`. Minimum event spacing is 2 cycles, and the block handles it.
- Precedence within one cycle: `reset` > `bypass` transition > `avgcntr_rst` > `upd_ev`.
- `reset` asserted mid-window or mid-ACQ returns all state to reset values immediately. The code restarts at CODE_INIT.

## Structure
- Package `bw_io_impctl_pkg` holds:
  - the state enum (ACQ, TRACK);
  - the CODE_W default and CODE_INIT default;
  - a saturating-step function (code, dir, step) → (code, sat).
- Sub-module `bw_io_impctl_avgwin` holds the TRACK-mode window counter, signed vote sum and decision logic. Its outputs are `dec_up`/`dec_dn` pulses. The top holds the FSM, edge detect and code register.

## Test plan
- Reset then `bypass`=1, `comp_up`=1, four update events → code 0x84, 0x88, 0x8C, 0x90, one `code_upd` each, `locked`=0.
- Acquisition lock: `bypass`=0 and `comp_up` pattern 1,0,1 → code 0x84, 0x80, 0x84; `locked`=1 the cycle after the third event's update.
- TRACK window with WIN=16: 10 ups and 6 downs (sum +4) → code +1 exactly once, after the 16th event. Then 9 ups and 7 downs (sum +2) → no change, no `code_upd`.
- Saturation: force code near 0xFE in ACQ with `comp_up`=1 → 0xFF, `sat_hi`=1. A further event gives no `code_upd`, and the code stays 0xFF.
- `avgcntr_rst` coincident with the 16th event after 15 ups → no code change. The window restarts, and 16 more ups produce +1.
- Async `reset` mid-window in TRACK → `imp_code`=0x80 and `locked`=0 immediately, with no `code_upd`.
